keypad_event_ctrl: RTL and testbench
====================================

Name: keypad_event_ctrl

Overview:
Sits between the 4x4 matrix keyboard scanner and the CPU I/O bus.
- Compares successive debounced 16-bit key snapshots.
- Serialises every press and release into ordered events, one per cycle, lowest key index first.
- Buffers the events in a small FIFO that the CPU drains through a valid/ready handshake.
- Turns a level-only key map into an interrupt-friendly event stream.

Parameters:
- DEPTH, 4, FIFO depth in events; power of two, minimum 2.
- REPEAT_DLY, 50, scan ticks a single held key must last before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_RATE, 10, scan ticks between subsequent auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- keys  in  16  debounced key map; bit 4*row+col is 1 while pressed.
- scan_tick  in  1  one-cycle pulse; keys holds a fresh full snapshot.
- ev_valid  out  1  FIFO head holds an event.
- ev_code  out  4  key index of the head event.
- ev_press  out  1  1 = press, 0 = release.
- ev_ready  in  1  consumer accepts the head when ev_valid is also 1.
- ev_count  out  clog2(DEPTH)+1  number of queued events.
- overflow  out  1  sticky flag; an event was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset value of all state and outputs is 0: prev map, pend mask, FIFO pointers, ev_valid, ev_code, ev_press, ev_count, overflow.
- The FSM has two states, IDLE and BUSY.

IDLE:
- When scan_tick=1: pend <= keys ^ prev and snap <= keys.
- Go to BUSY if (keys ^ prev) != 0; otherwise stay in IDLE.

BUSY:
- Each cycle, select i = lowest set bit of pend.
- Push event {code=i, press=snap[i]}.
- Clear pend[i] and set prev[i] <= snap[i].
- When the cleared pend becomes 0, return to IDLE in the next cycle.

Latency and ordering:
- A change of n bits produces n events in n consecutive cycles.
- First event appears on ev_valid 2 cycles after the scan_tick edge: cycle t tick, t+1 push, t+2 visible.
- Worst-case BUSY length is 16 cycles.

scan_tick while BUSY:
- The tick is ignored.
- Nothing is lost, because prev only tracks bits already reported; the next accepted tick re-diffs.

FIFO:
- Standard synchronous FIFO; the head is registered.
- Pop occurs when ev_valid && ev_ready.
- Push when full without a same-cycle pop: event dropped, overflow <= 1, prev still updated (no re-report).
- Push when full with a same-cycle pop: push succeeds and ev_count is unchanged.
- Pop when empty is ignored.
- Read and write pointers wrap modulo DEPTH; ev_count is exact from 0 to DEPTH.

overflow:
- Set by a drop, cleared by ovf_clr.
- If set and clear occur in the same cycle, set wins.

Reset mid-BUSY:
- Returns to IDLE with prev=0.
- Keys still held at the first tick after reset are reported as presses.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: when a scan_tick finds no change and exactly one bit of prev is set, a per-tick hold counter increments.
- When the counter reaches REPEAT_DLY, a press event for that key is pushed, and then again every REPEAT_RATE ticks.
- Any change in keys, or zero or several keys held, clears the counter.
- Repeat pushes use the normal FIFO and overflow rules and are issued from IDLE only.
- Undefined: no hold counter, and only real transitions produce events.

Decomposition:
- Shared header keypad_defs.vh holds:
  - KEY_W=4 and MAP_W=16.
  - Event field offsets: code [3:0], press [4].
  - FSM state encodings IDLE=0 and BUSY=1.
- One sub-module, keypad_event_fifo: parameterised DEPTH, 5-bit wide, with push/pop/full/empty/count.
- Priority select and diff logic stay in the top module.

Test Plan:
1. Reset, keys=0x0001, pulse scan_tick -> 2 cycles later ev_valid=1, ev_code=0, ev_press=1; ev_count=1.
2. keys 0x0001 -> 0x8010, tick -> three events in order: (0,release), (4,press), (15,press) on consecutive push cycles.
3. DEPTH=4 with ev_ready=0: change 6 keys in one tick -> ev_count=4, overflow=1, last two events dropped; a second tick with unchanged keys produces no events.
4. FIFO full, ev_ready=1 during a push cycle -> ev_count stays 4 and the head advances; ovf_clr together with a drop leaves overflow=1.
5. scan_tick pulsed on every cycle while BUSY with 8 changed keys -> exactly 8 events, no duplicates; Reset asserted mid-BUSY -> ev_valid=0 and ev_count=0 immediately.
6. KEYPAD_REPEAT_EN with REPEAT_DLY=3, REPEAT_RATE=2: hold key 5 -> press events at the initial tick, then ticks +3, +5, +7; pressing a second key stops the repeat.

Source files
------------

// File: rtl/keypad_event_ctrl_pkg.sv
// ============================================================================
//  Module      : keypad_event_ctrl_pkg
//  Description : Shared widths, event field offsets, FSM encoding and the
//                lowest-set-bit helper for the keypad event controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package keypad_event_ctrl_pkg;

    localparam int KEY_W        = 4;
    localparam int MAP_W        = 16;
    localparam int EV_W         = 5;
    localparam int EV_CODE_LSB  = 0;
    localparam int EV_CODE_MSB  = 3;
    localparam int EV_PRESS_BIT = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index of the lowest set bit; the scan runs high to low so the last hit wins.
    function automatic logic [KEY_W-1:0] lowest_index(input logic [MAP_W-1:0] m);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = MAP_W - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = i[KEY_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_event_ctrl_fifo.sv
// ============================================================================
//  Module      : keypad_event_fifo
//  Description : Synchronous event FIFO, power-of-two depth. A push into a
//                full FIFO succeeds only when a pop happens in the same cycle;
//                otherwise it is reported on 'drop'.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign pop_data = mem[rd_ptr];

    // Storage array; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy exactly.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_event_ctrl.sv
// ============================================================================
//  Module      : keypad_event_ctrl
//  Description : Diffs successive debounced 4x4 key snapshots, serialises the
//                changes into press/release events (lowest key first, one per
//                cycle) and queues them for the CPU.
//                Optional auto-repeat of a single held key: KEYPAD_REPEAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_event_ctrl
    import keypad_event_ctrl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [15:0]             keys,
    input  logic                    scan_tick,
    output logic                    ev_valid,
    output logic [3:0]              ev_code,
    output logic                    ev_press,
    input  logic                    ev_ready,
    output logic [$clog2(DEPTH):0]  ev_count,
    output logic                    overflow,
    input  logic                    ovf_clr
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_param_check
            $error("keypad_event_ctrl: illegal parameter value");
        end
    endgenerate

    state_t             state;
    state_t             state_next;
    logic [MAP_W-1:0]   prev;
    logic [MAP_W-1:0]   pend;
    logic [MAP_W-1:0]   snap;
    logic [MAP_W-1:0]   diff;
    logic [MAP_W-1:0]   pend_clr;
    logic [KEY_W-1:0]   sel;
    logic               push;
    logic [EV_W-1:0]    push_ev;
    logic [EV_W-1:0]    head_ev;
    logic               fifo_empty;
    logic               fifo_full;
    logic               drop;

    assign diff     = keys ^ prev;
    assign sel      = lowest_index(pend);
    assign pend_clr = pend & ~(MAP_W'(1) << sel);

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(REP_MAX + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rep_target;
    logic             rep_active;
    logic             prev_onehot;
    logic             rep_elig;
    logic             rep_fire;

    assign prev_onehot = (prev != '0) && ((prev & (prev - MAP_W'(1))) == '0);
    assign rep_elig    = (state == IDLE) && scan_tick && (diff == '0) && prev_onehot;
    assign cnt_inc     = hold_cnt + 1'b1;
    assign rep_target  = rep_active ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DLY);
    assign rep_fire    = rep_elig && (cnt_inc == rep_target);

    // Hold counter: first target is the initial delay, then the repeat rate.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hold_cnt   <= '0;
            rep_active <= 1'b0;
        end else if (state == IDLE && scan_tick) begin
            if (rep_fire) begin
                hold_cnt   <= '0;
                rep_active <= 1'b1;
            end else if (rep_elig) begin
                hold_cnt   <= cnt_inc;
            end else begin
                hold_cnt   <= '0;
                rep_active <= 1'b0;
            end
        end
    end
`else
    logic rep_fire;
    assign rep_fire = 1'b0;
`endif

    // Next state and event push: BUSY emits the lowest pending change each cycle.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_ev    = '0;
        case (state)
            IDLE: begin
                if (scan_tick && diff != '0) begin
                    state_next = BUSY;
                end else if (rep_fire) begin
                    push    = 1'b1;
                    push_ev = {1'b1, lowest_index(prev)};
                end
            end
            BUSY: begin
                push    = 1'b1;
                push_ev = {snap[sel], sel};
                if (pend_clr == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot capture in IDLE; prev only absorbs bits as they are reported,
    // so a tick ignored while BUSY loses nothing.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prev <= '0;
            pend <= '0;
            snap <= '0;
        end else if (state == IDLE) begin
            if (scan_tick) begin
                pend <= diff;
                snap <= keys;
            end
        end else begin
            pend      <= pend_clr;
            prev[sel] <= snap[sel];
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    keypad_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_ready),
        .pop_data  (head_ev),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (ev_count),
        .drop      (drop)
    );

    assign ev_valid = !fifo_empty;
    assign ev_code  = head_ev[EV_CODE_MSB:EV_CODE_LSB];
    assign ev_press = head_ev[EV_PRESS_BIT];

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

`default_nettype wire

// File: tb/tb_keypad_event_ctrl.sv
// ============================================================================
//  Module      : tb_keypad_event_ctrl
//  Description : Self-checking bench for keypad_event_ctrl. Expected events are
//                queued as stimulus is issued; a monitor pops and compares on
//                every accepted handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_event_ctrl;

    logic        Clock;
    logic        Reset;
    logic [15:0] keys;
    logic        scan_tick;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic        ev_press;
    logic        ev_ready;
    logic [2:0]  ev_count;
    logic        overflow;
    logic        ovf_clr;

    int          n_chk;
    int          n_fail;
    logic [4:0]  sb[$];

    keypad_event_ctrl #(
        .DEPTH       (4),
        .REPEAT_DLY  (3),
        .REPEAT_RATE (2)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .keys      (keys),
        .scan_tick (scan_tick),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_press  (ev_press),
        .ev_ready  (ev_ready),
        .ev_count  (ev_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Monitor: compare every accepted head against the scoreboard.
    always @(negedge Clock) begin
        if (Reset && ev_valid && ev_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got code=%0d press=%0b, none expected", ev_code, ev_press);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                if ({ev_press, ev_code} !== e) begin
                    n_fail++;
                    $display("FAIL event: got code=%0d press=%0b, expected code=%0d press=%0b",
                             ev_code, ev_press, e[3:0], e[4]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic tick(input logic [15:0] v);
        keys      = v;
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
    endtask

    task automatic expect_ev(input int code, input bit press);
        sb.push_back({press, 4'(code)});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((ev_count != 0 || sb.size() != 0) && n < 60) begin
            step();
            n++;
        end
        check(name, {29'd0, ev_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        Reset     = 1'b0;
        keys      = '0;
        scan_tick = 1'b0;
        ev_ready  = 1'b0;
        ovf_clr   = 1'b0;
        step();
        step();
        check("rst_valid", {31'd0, ev_valid}, 32'd0);
        check("rst_count", {29'd0, ev_count}, 32'd0);
        check("rst_ovf",   {31'd0, overflow}, 32'd0);
        check("rst_code",  {27'd0, ev_press, ev_code}, 32'd0);
        Reset = 1'b1;
        step();

        // Single press: visible two edges after the tick edge.
        expect_ev(0, 1'b1);
        tick(16'h0001);
        check("t1_not_yet", {31'd0, ev_valid}, 32'd0);
        step();
        check("t1_valid", {31'd0, ev_valid}, 32'd1);
        check("t1_head",  {27'd0, ev_press, ev_code}, 32'h10);
        check("t1_count", {29'd0, ev_count}, 32'd1);
        ev_ready = 1'b1;
        wait_drain("t1_drain");

        // Mixed release/press, lowest index first, one per cycle.
        ev_ready = 1'b0;
        expect_ev(0, 1'b0);
        expect_ev(4, 1'b1);
        expect_ev(15, 1'b1);
        tick(16'h8010);
        check("t2_c0", {29'd0, ev_count}, 32'd0);
        step();
        check("t2_c1", {29'd0, ev_count}, 32'd1);
        step();
        check("t2_c2", {29'd0, ev_count}, 32'd2);
        step();
        check("t2_c3", {29'd0, ev_count}, 32'd3);
        step();
        check("t2_c3_hold", {29'd0, ev_count}, 32'd3);
        ev_ready = 1'b1;
        wait_drain("t2_drain");

        // Six changes into a 4-deep FIFO: two drops, no re-report afterwards.
        ev_ready = 1'b0;
        expect_ev(0, 1'b1);
        expect_ev(1, 1'b1);
        expect_ev(2, 1'b1);
        expect_ev(3, 1'b1);
        tick(16'h802F);
        repeat (7) step();
        check("t3_count", {29'd0, ev_count}, 32'd4);
        check("t3_ovf",   {31'd0, overflow}, 32'd1);
        check("t3_head",  {27'd0, ev_press, ev_code}, 32'h10);
        tick(16'h802F);
        repeat (3) step();
        check("t3_no_rereport", {29'd0, ev_count}, 32'd4);

        // Full FIFO: pop+push keeps count; drop with clear keeps overflow set.
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        expect_ev(8, 1'b1);
        tick(16'h872F);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        ovf_clr  = 1'b1;
        check("t4_count_same", {29'd0, ev_count}, 32'd4);
        check("t4_head_adv",   {27'd0, ev_press, ev_code}, 32'h11);
        step();
        ovf_clr = 1'b0;
        check("t4_set_wins", {31'd0, overflow}, 32'd1);
        step();
        check("t4_count_full", {29'd0, ev_count}, 32'd4);
        ev_ready = 1'b1;
        wait_drain("t4_drain");
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        // Eight changes with scan_tick held high through BUSY.
        expect_ev(8, 1'b0);
        expect_ev(9, 1'b0);
        expect_ev(10, 1'b0);
        expect_ev(11, 1'b1);
        expect_ev(12, 1'b1);
        expect_ev(13, 1'b1);
        expect_ev(14, 1'b1);
        expect_ev(15, 1'b0);
        keys      = 16'h782F;
        scan_tick = 1'b1;
        repeat (11) step();
        scan_tick = 1'b0;
        wait_drain("t5_drain");
        check("t5_ovf", {31'd0, overflow}, 32'd0);

        // Reset in the middle of a BUSY burst.
        ev_ready = 1'b0;
        tick(16'h0003);
        step();
        step();
        check("t5_pre_rst", {29'd0, ev_count}, 32'd2);
        Reset = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, ev_valid}, 32'd0);
        check("t5_rst_count", {29'd0, ev_count}, 32'd0);
        step();
        Reset = 1'b1;
        step();
        expect_ev(0, 1'b1);
        expect_ev(1, 1'b1);
        tick(16'h0003);
        ev_ready = 1'b1;
        wait_drain("t5_rereport");

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat of key 5 at hold ticks 3, 5, 7; a second key stops it.
        expect_ev(0, 1'b0);
        expect_ev(1, 1'b0);
        tick(16'h0000);
        repeat (3) step();
        expect_ev(5, 1'b1);
        tick(16'h0020);
        repeat (3) step();
        for (int k = 1; k <= 8; k++) begin
            if (k == 3 || k == 5 || k == 7) begin
                expect_ev(5, 1'b1);
            end
            tick(16'h0020);
            repeat (3) step();
        end
        expect_ev(6, 1'b1);
        tick(16'h0060);
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            tick(16'h0060);
            repeat (3) step();
        end
        wait_drain("t6_drain");
`endif

        repeat (4) step();
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
